// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encodings,
// the NOP instruction and default memory geometry.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        LD_LOAD  = 2'd0,
        LD_RUN   = 2'd1,
        LD_ERROR = 2'd2
    } ld_state_e;

    localparam logic [31:0] NOP_INS    = 32'h0000_0000;
    localparam int          IMEM_DEPTH = 256;
    localparam int          IMEM_AW    = 8;

endpackage

// File: rtl/imem_loader_ram.sv
// Instruction RAM: DEPTH x 32 with one synchronous write port and one
// asynchronous read port, so a word written at an edge is visible right after it.
module imem_ram
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader in front of execute: packs big-endian bytes into
// words, fills the instruction RAM and releases the CPU once a whole program is in.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic          clk,
    input  logic          rstd,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          reload,
    input  logic [31:0]   pc,
    output logic [31:0]   ins,
    output logic          run,
    output logic          load_err,
    output logic [AW:0]   word_count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    ld_state_e   state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] asm_q, asm_d;
    logic [AW:0] word_count_q, word_count_d;

    logic          accept;
    logic          full;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          pc_hit;

    assign accept = ld_valid && (state_q == LD_LOAD);
    assign full   = (word_count_q == FULL_COUNT);

    always_ff @(posedge clk) begin
        if (rstd) begin
            state_q      <= LD_LOAD;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        word_count_d = word_count_q;
        ram_we       = 1'b0;
        ram_waddr    = word_count_q[AW-1:0];
        ram_wdata    = {asm_q, ld_data};

        unique case (state_q)
            LD_LOAD: begin
                if (accept) begin
                    // A byte arriving with the RAM already full is an overflow, never a wrap.
                    if (full) begin
                        state_d = LD_ERROR;
                    end else if (byte_cnt_q == 2'd3) begin
                        ram_we       = 1'b1;
                        word_count_d = word_count_q + 1'b1;
                        byte_cnt_d   = 2'd0;
                        if (ld_last) begin
                            state_d = LD_RUN;
                        end
                    end else begin
                        asm_d      = {asm_q[15:0], ld_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (ld_last) begin
                            state_d = LD_ERROR;
                        end
                    end
                end
            end
            LD_RUN, LD_ERROR: begin
                if (reload) begin
                    state_d      = LD_LOAD;
                    word_count_d = '0;
                    byte_cnt_d   = 2'd0;
                end
            end
            default: begin
                state_d = LD_LOAD;
            end
        endcase
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (pc[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Stale RAM beyond the current program, or any out-of-range pc, reads as NOP.
    assign pc_hit = run && (pc[31:AW] == '0) &&
                    ({1'b0, pc[AW-1:0]} < word_count_q);

    assign ins        = pc_hit ? ram_rdata : NOP_INS;
    assign ld_ready   = (state_q == LD_LOAD);
    assign run        = (state_q == LD_RUN);
    assign load_err   = (state_q == LD_ERROR);
    assign word_count = word_count_q;

endmodule
